// File: rtl/arith_pkg.sv
// Shared arithmetic definitions for the filter-pipeline divider: FSM states,
// default widths and the divide-by-zero quotient value.
package arith_pkg;

  localparam int unsigned DIV_N_W = 8;
  localparam int unsigned DIV_D_W = 4;

  // Counter must hold N_W-1; keep at least one bit for degenerate widths.
  function automatic int unsigned div_cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned DIV_CNT_W = div_cnt_w(DIV_N_W);

  localparam logic [DIV_N_W-1:0] DIV_Q_ONES = '1;

  typedef enum logic [1:0] {
    DIV_IDLE  = 2'd0,
    DIV_BUSY  = 2'd1,
    DIV_ROUND = 2'd2,
    DIV_DONE  = 2'd3
  } div_state_e;

endpackage

// File: rtl/seq_restoring_divider_if.sv
// Operand and result valid/ready bundle for the restoring divider.
interface seq_restoring_divider_if import arith_pkg::*; #(
  parameter int unsigned N_W = DIV_N_W,
  parameter int unsigned D_W = DIV_D_W
) ();

  logic           in_valid;
  logic           in_ready;
  logic [N_W-1:0] dividend;
  logic [D_W-1:0] divisor;
  logic           out_valid;
  logic           out_ready;
  logic [N_W-1:0] quotient;
  logic [D_W-1:0] remainder;
  logic           div_by_zero;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/seq_restoring_divider_div_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// trial-subtract the divisor, keep the difference when it does not go negative.
module div_step import arith_pkg::*; #(
  parameter int unsigned D_W = DIV_D_W
) (
  input  logic [D_W-1:0] p_in,
  input  logic           dvd_bit,
  input  logic [D_W-1:0] divisor,
  output logic [D_W-1:0] p_out,
  output logic           q_bit
);

  logic [D_W:0] p_shift;

  assign p_shift = {p_in, dvd_bit};
  assign q_bit   = (p_shift >= {1'b0, divisor});
  // The kept value is always below the divisor, so it fits D_W bits.
  assign p_out   = D_W'(q_bit ? (p_shift - {1'b0, divisor}) : p_shift);

endmodule

// File: rtl/seq_restoring_divider.sv
// Iterative unsigned restoring divider, one quotient bit per clock.
// Define DIV_ROUND_EN to add a round-to-nearest cycle after the last step.
module seq_restoring_divider import arith_pkg::*; #(
  parameter int unsigned N_W = DIV_N_W,
  parameter int unsigned D_W = DIV_D_W
) (
  input logic              clk,
  input logic              aresetn,
  input logic              clear,
  seq_restoring_divider_if.slave bus
);

  localparam int unsigned CntW = div_cnt_w(N_W);

  div_state_e     state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [D_W-1:0] p_q, p_d;
  logic [D_W-1:0] dvs_q, dvs_d;
  logic [N_W-1:0] sh_q, sh_d;
  logic [N_W-1:0] quot_q, quot_d;
  logic [D_W-1:0] rem_q, rem_d;
  logic           dbz_q, dbz_d;

  logic [D_W-1:0] step_p;
  logic           step_q;

  div_step #(
    .D_W (D_W)
  ) u_step (
    .p_in    (p_q),
    .dvd_bit (sh_q[N_W-1]),
    .divisor (dvs_q),
    .p_out   (step_p),
    .q_bit   (step_q)
  );

`ifdef DIV_ROUND_EN
  logic round_up;
  assign round_up = ({p_q, 1'b0} >= {1'b0, dvs_q});
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    dvs_d   = dvs_q;
    sh_d    = sh_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    if (clear) begin
      state_d = DIV_IDLE;
      cnt_d   = '0;
      p_d     = '0;
      dvs_d   = '0;
      sh_d    = '0;
      quot_d  = '0;
      rem_d   = '0;
      dbz_d   = 1'b0;
    end else begin
      unique case (state_q)
        DIV_IDLE: begin
          if (bus.in_valid) begin
            sh_d    = bus.dividend;
            dvs_d   = bus.divisor;
            p_d     = '0;
            cnt_d   = CntW'(N_W - 1);
            state_d = DIV_BUSY;
          end
        end
        DIV_BUSY: begin
          // A zero divisor spends exactly one BUSY cycle, then reports saturation.
          if (dvs_q == '0) begin
            quot_d  = '1;
            rem_d   = '0;
            dbz_d   = 1'b1;
            state_d = DIV_DONE;
          end else begin
            p_d   = step_p;
            sh_d  = {sh_q[N_W-2:0], step_q};
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == '0) begin
`ifdef DIV_ROUND_EN
              state_d = DIV_ROUND;
`else
              quot_d  = {sh_q[N_W-2:0], step_q};
              rem_d   = step_p;
              dbz_d   = 1'b0;
              state_d = DIV_DONE;
`endif
            end
          end
        end
`ifdef DIV_ROUND_EN
        DIV_ROUND: begin
          quot_d  = (round_up && !(&sh_q)) ? (sh_q + 1'b1) : sh_q;
          rem_d   = p_q;
          dbz_d   = 1'b0;
          state_d = DIV_DONE;
        end
`endif
        DIV_DONE: begin
          if (bus.out_ready) begin
            state_d = DIV_IDLE;
          end
        end
        default: state_d = DIV_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
      p_q     <= '0;
      dvs_q   <= '0;
      sh_q    <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      dvs_q   <= dvs_d;
      sh_q    <= sh_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  // Not ready while reset is held, even though the state already reads IDLE.
  assign bus.in_ready    = (state_q == DIV_IDLE) && aresetn;
  assign bus.out_valid   = (state_q == DIV_DONE);
  assign bus.quotient    = quot_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed bench for seq_restoring_divider; follows DIV_ROUND_EN when defined.
module tb_seq_restoring_divider;
  import arith_pkg::*;

  localparam int unsigned N_W = 8;
  localparam int unsigned D_W = 4;
`ifdef DIV_ROUND_EN
  localparam int RND = 1;
`else
  localparam int RND = 0;
`endif
  localparam int LAT = 8 + RND;

  logic clk     = 1'b0;
  logic aresetn = 1'b0;
  logic clear   = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  seq_restoring_divider_if #(.N_W(N_W), .D_W(D_W)) bus ();

  seq_restoring_divider #(
    .N_W (N_W),
    .D_W (D_W)
  ) dut (
    .clk     (clk),
    .aresetn (aresetn),
    .clear   (clear),
    .bus     (bus)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Called #1 after a rising edge with the divider idle.
  task automatic run_op(input string tag, input logic [7:0] dvd, input logic [3:0] dvs,
                        input logic [7:0] eq, input logic [3:0] er, input logic edbz,
                        input int elat, input int stall, input bit hold);
    int lat;
    bit seen;
    lat  = 0;
    seen = 1'b0;
    check_eq({tag, " in_ready idle"}, 32'(bus.in_ready), 1);
    bus.in_valid = 1'b1;
    bus.dividend = dvd;
    bus.divisor  = dvs;
    @(posedge clk); #1;
    if (!hold) bus.in_valid = 1'b0;
    while (!seen && lat < 20) begin
      check_eq({tag, " in_ready busy"}, 32'(bus.in_ready), 0);
      @(posedge clk); #1;
      lat++;
      seen = bus.out_valid;
    end
    check_eq({tag, " latency"}, 32'(lat), 32'(elat));
    check_eq({tag, " quotient"}, 32'(bus.quotient), 32'(eq));
    check_eq({tag, " remainder"}, 32'(bus.remainder), 32'(er));
    check_eq({tag, " div_by_zero"}, 32'(bus.div_by_zero), 32'(edbz));
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      check_eq({tag, " stall out_valid"}, 32'(bus.out_valid), 1);
      check_eq({tag, " stall quotient"}, 32'(bus.quotient), 32'(eq));
      check_eq({tag, " stall remainder"}, 32'(bus.remainder), 32'(er));
      check_eq({tag, " stall in_ready"}, 32'(bus.in_ready), 0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    check_eq({tag, " out_valid dropped"}, 32'(bus.out_valid), 0);
    check_eq({tag, " in_ready after"}, 32'(bus.in_ready), 1);
    check_eq({tag, " quotient kept"}, 32'(bus.quotient), 32'(eq));
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    bus.out_ready = 1'b0;

    #2;
    check_eq("rst in_ready", 32'(bus.in_ready), 0);
    check_eq("rst out_valid", 32'(bus.out_valid), 0);
    check_eq("rst quotient", 32'(bus.quotient), 0);
    check_eq("rst remainder", 32'(bus.remainder), 0);
    check_eq("rst div_by_zero", 32'(bus.div_by_zero), 0);
    @(negedge clk);
    aresetn = 1'b1;
    @(posedge clk); #1;
    check_eq("release in_ready", 32'(bus.in_ready), 1);

    run_op("200/7", 8'd200, 4'd7, (RND != 0) ? 8'd29 : 8'd28, 4'd4, 1'b0, LAT, 0, 1'b0);
    run_op("13/0", 8'd13, 4'd0, DIV_Q_ONES, 4'd0, 1'b1, 1, 0, 1'b0);
    run_op("255/1", 8'd255, 4'd1, 8'd255, 4'd0, 1'b0, LAT, 0, 1'b1);
    run_op("0/5", 8'd0, 4'd5, 8'd0, 4'd0, 1'b0, LAT, 0, 1'b1);
    run_op("9/15", 8'd9, 4'd15, (RND != 0) ? 8'd1 : 8'd0, 4'd9, 1'b0, LAT, 0, 1'b1);
    run_op("100/3", 8'd100, 4'd3, 8'd33, 4'd1, 1'b0, LAT, 5, 1'b0);

    // Abort 200/7 in its fourth BUSY cycle.
    bus.in_valid = 1'b1;
    bus.dividend = 8'd200;
    bus.divisor  = 4'd7;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    check_eq("clear out_valid", 32'(bus.out_valid), 0);
    check_eq("clear quotient", 32'(bus.quotient), 0);
    check_eq("clear remainder", 32'(bus.remainder), 0);
    check_eq("clear div_by_zero", 32'(bus.div_by_zero), 0);
    check_eq("clear in_ready", 32'(bus.in_ready), 1);
    @(posedge clk); #1;
    check_eq("clear stays idle", 32'(bus.out_valid), 0);
    run_op("50/6", 8'd50, 4'd6, 8'd8, 4'd2, 1'b0, LAT, 0, 1'b0);

    // Asynchronous reset in the middle of BUSY.
    bus.in_valid = 1'b1;
    bus.dividend = 8'd200;
    bus.divisor  = 4'd7;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    aresetn = 1'b0;
    #1;
    check_eq("async rst quotient", 32'(bus.quotient), 0);
    check_eq("async rst remainder", 32'(bus.remainder), 0);
    check_eq("async rst out_valid", 32'(bus.out_valid), 0);
    check_eq("async rst in_ready", 32'(bus.in_ready), 0);
    @(negedge clk);
    aresetn = 1'b1;
    @(posedge clk); #1;
    check_eq("async release in_ready", 32'(bus.in_ready), 1);
    check_eq("async release out_valid", 32'(bus.out_valid), 0);
    run_op("17/4", 8'd17, 4'd4, 8'd4, 4'd1, 1'b0, LAT, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
